// File: rtl/rr_arbiter4_pkg.sv
// Shared definitions for the four-way round-robin arbiter: FSM encoding,
// parameter defaults and the one-hot grant helper.
package rr_arbiter4_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    localparam int NREQ         = 4;
    localparam int MAX_HOLD_DEF = 8;
    localparam int CNT_W_DEF    = 8;

    function automatic logic [NREQ-1:0] onehot4(input logic [1:0] idx);
        logic [NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational circular priority picker: returns the first set request bit
// at or after ptr, wrapping modulo four.
module rr_pick4
    import rr_arbiter4_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      ptr,
    output logic [1:0]      sel,
    output logic            any
);

    logic [NREQ-1:0] w_rot;
    logic [1:0]      w_off;

    // Rotate so that bit 0 of w_rot is the requester currently holding top priority.
    always_comb begin
        case (ptr)
            2'd0:    w_rot = req;
            2'd1:    w_rot = {req[0],   req[3:1]};
            2'd2:    w_rot = {req[1:0], req[3:2]};
            default: w_rot = {req[2:0], req[3]};
        endcase
    end

    always_comb begin
        w_off = 2'd0;
        if (w_rot[0])      w_off = 2'd0;
        else if (w_rot[1]) w_off = 2'd1;
        else if (w_rot[2]) w_off = 2'd2;
        else if (w_rot[3]) w_off = 2'd3;
    end

    assign sel = ptr + w_off;
    assign any = |req;

endmodule

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter with registered one-hot grant, rotating
// priority pointer and bounded tenure (forced release after MAX_HOLD cycles).
module rr_arbiter4
    import rr_arbiter4_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] grant,
    output logic [1:0] grant_id,
    output logic       busy,
    output logic       timeout
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_e           r_state,    w_state_nxt;
    logic [3:0]       r_grant,    w_grant_nxt;
    logic [1:0]       r_grant_id, w_grant_id_nxt;
    logic             r_busy,     w_busy_nxt;
    logic             r_timeout,  w_timeout_nxt;
    logic [1:0]       r_ptr,      w_ptr_nxt;
    logic [CNT_W-1:0] r_hold_cnt, w_hold_nxt;

    logic [1:0]       w_sel;
    logic             w_any;
    logic             w_release;
    logic             w_forced;

    rr_pick4 u_pick (
        .req (req),
        .ptr (r_ptr),
        .sel (w_sel),
        .any (w_any)
    );

    // Release priority: done, then withdrawal, then tenure limit; only the last raises timeout.
    assign w_release = done || !req[r_grant_id] || (r_hold_cnt == HOLD_LAST);
    assign w_forced  = !done && req[r_grant_id];

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
        w_state_nxt    = r_state;
        w_grant_nxt    = r_grant;
        w_grant_id_nxt = r_grant_id;
        w_busy_nxt     = r_busy;
        w_timeout_nxt  = 1'b0;
        w_ptr_nxt      = r_ptr;
        w_hold_nxt     = r_hold_cnt;

        case (r_state)
            IDLE: begin
                w_hold_nxt = '0;
                if (w_any) begin
                    w_state_nxt    = GRANT;
                    w_grant_nxt    = onehot4(w_sel);
                    w_grant_id_nxt = w_sel;
                    w_busy_nxt     = 1'b1;
                end else begin
                    w_grant_nxt    = '0;
                    w_grant_id_nxt = '0;
                    w_busy_nxt     = 1'b0;
                end
            end
            GRANT: begin
                if (w_release) begin
                    w_state_nxt    = IDLE;
                    w_grant_nxt    = '0;
                    w_grant_id_nxt = '0;
                    w_busy_nxt     = 1'b0;
                    w_timeout_nxt  = w_forced;
                    w_ptr_nxt      = r_grant_id + 2'd1;
                    w_hold_nxt     = '0;
                end else begin
                    w_hold_nxt     = r_hold_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt    = IDLE;
                w_grant_nxt    = '0;
                w_grant_id_nxt = '0;
                w_busy_nxt     = 1'b0;
                w_hold_nxt     = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_grant_id <= '0;
            r_busy     <= 1'b0;
            r_timeout  <= 1'b0;
            r_ptr      <= '0;
            r_hold_cnt <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_grant_id <= w_grant_id_nxt;
            r_busy     <= w_busy_nxt;
            r_timeout  <= w_timeout_nxt;
            r_ptr      <= w_ptr_nxt;
            r_hold_cnt <= w_hold_nxt;
        end
    end

    assign grant    = r_grant;
    assign grant_id = r_grant_id;
    assign busy     = r_busy;
    assign timeout  = r_timeout;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed scoreboard bench for rr_arbiter4: expected output vectors are queued
// when inputs are driven and compared one cycle later.
module tb_rr_arbiter4;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       busy;
    logic       timeout;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string      tag;
        logic [7:0] vec;
    } exp_t;

    exp_t sb_q[$];

    rr_arbiter4 #(.MAX_HOLD(8), .CNT_W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .done     (done),
        .grant    (grant),
        .grant_id (grant_id),
        .busy     (busy),
        .timeout  (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {grant, grant_id, busy, timeout} derived from the expected grant alone.
    function automatic logic [7:0] exp_vec(input logic [3:0] g, input logic t);
        logic [1:0] id;
        id = 2'd0;
        if (g[1]) id = 2'd1;
        if (g[2]) id = 2'd2;
        if (g[3]) id = 2'd3;
        return {g, id, (g != 4'b0000), t};
    endfunction

    task automatic push(input string tag, input logic [3:0] g, input logic t);
        exp_t e;
        e.tag = tag;
        e.vec = exp_vec(g, t);
        sb_q.push_back(e);
    endtask

    task automatic compare_pop();
        exp_t       e;
        logic [7:0] obs;
        obs = {grant, grant_id, busy, timeout};
        total++;
        if (sb_q.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty: got %b want <queued entry>", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.vec) else begin
                bad++;
                $error("FAIL %s: got grant=%b id=%0d busy=%b to=%b want grant=%b id=%0d busy=%b to=%b",
                       e.tag, obs[7:4], obs[3:2], obs[1], obs[0],
                       e.vec[7:4], e.vec[3:2], e.vec[1], e.vec[0]);
            end
        end
    endtask

    task automatic step(input string tag, input logic [3:0] r, input logic d,
                        input logic [3:0] eg, input logic et);
        @(negedge clk);
        req  = r;
        done = d;
        push(tag, eg, et);
        @(posedge clk);
        #1;
        compare_pop();
    endtask

    initial begin
        reset = 1'b1;
        req   = 4'b0000;
        done  = 1'b0;

        // Reset state, then a first grant, then reset asserted mid-grant at t=10.
        #1;
        push("reset_state", 4'b0000, 1'b0);
        compare_pop();
        reset = 1'b0;
        req   = 4'b0001;
        push("first_grant", 4'b0001, 1'b0);
        @(posedge clk);
        #1;
        compare_pop();
        #4;
        reset = 1'b1;
        req   = 4'b0000;
        push("reset_mid_grant", 4'b0000, 1'b0);
        #1;
        compare_pop();
        @(negedge clk);
        reset = 1'b0;
        step("post_reset_idle", 4'b0000, 1'b0, 4'b0000, 1'b0);
        step("post_reset_req3", 4'b1000, 1'b0, 4'b1000, 1'b0);
        step("withdraw3",       4'b0000, 1'b0, 4'b0000, 1'b0);

        // All-request rotation with done one cycle after each grant.
        step("rot_g0",  4'b1111, 1'b0, 4'b0001, 1'b0);
        step("rot_r0",  4'b1111, 1'b1, 4'b0000, 1'b0);
        step("rot_g1",  4'b1111, 1'b0, 4'b0010, 1'b0);
        step("rot_r1",  4'b1111, 1'b1, 4'b0000, 1'b0);
        step("rot_g2",  4'b1111, 1'b0, 4'b0100, 1'b0);
        step("rot_r2",  4'b1111, 1'b1, 4'b0000, 1'b0);
        step("rot_g3",  4'b1111, 1'b0, 4'b1000, 1'b0);
        step("rot_r3",  4'b1111, 1'b1, 4'b0000, 1'b0);
        step("rot_g0b", 4'b1111, 1'b0, 4'b0001, 1'b0);
        step("rot_r0b", 4'b1111, 1'b1, 4'b0000, 1'b0);

        // Owner 1 releases (ptr=2); req=0011 must wrap to requester 0.
        step("prio_g1",   4'b0010, 1'b0, 4'b0010, 1'b0);
        step("prio_r1",   4'b0010, 1'b1, 4'b0000, 1'b0);
        step("prio_wrap", 4'b0011, 1'b0, 4'b0001, 1'b0);
        step("prio_r0",   4'b0011, 1'b1, 4'b0000, 1'b0);

        // Timeout: grant held 8 cycles, then one idle cycle with timeout, then re-grant.
        step("to_grant", 4'b0100, 1'b0, 4'b0100, 1'b0);
        for (int i = 0; i < 7; i++)
            step("to_hold", 4'b0100, 1'b0, 4'b0100, 1'b0);
        step("to_release", 4'b0100, 1'b0, 4'b0000, 1'b1);
        step("to_regrant", 4'b0100, 1'b0, 4'b0100, 1'b0);

        // done on the 8th held cycle wins over the tenure limit.
        for (int i = 0; i < 7; i++)
            step("dt_hold", 4'b0100, 1'b0, 4'b0100, 1'b0);
        step("dt_done_wins", 4'b0100, 1'b1, 4'b0000, 1'b0);

        // Withdrawal on cycle 3, then ptr=1 steers req=0011 to requester 1.
        step("wd_grant",   4'b0001, 1'b0, 4'b0001, 1'b0);
        step("wd_hold",    4'b0001, 1'b0, 4'b0001, 1'b0);
        step("wd_release", 4'b0000, 1'b0, 4'b0000, 1'b0);
        step("wd_next",    4'b0011, 1'b0, 4'b0010, 1'b0);
        step("wd_done",    4'b0011, 1'b1, 4'b0000, 1'b0);
        step("final_idle", 4'b0000, 1'b0, 4'b0000, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rr_arbiter4.md
Name: rr_arbiter4

Overview:
- Four-way round-robin arbiter with a one-hot registered grant. Shares a single resource (the four-state one-hot FSM datapath) between four requesters.
- Tracks a rotating priority pointer and a bounded tenure per grant, so no single requester can hold the resource indefinitely.
- Sits between the requester logic and the shared FSM. The one-hot grant style mirrors the FSM's s0..s3 outputs.

Parameters:
- MAX_HOLD, 8, maximum cycles one owner may hold the grant before forced release; legal range 2..255.
- CNT_W, 8, width of the tenure counter; must satisfy 2**CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  4  request lines; bit i = requester i, level-sensitive.
- done  input  1  current owner finished; sampled only in GRANT.
- grant  output  4  one-hot grant, registered; all-zero when idle.
- grant_id  output  2  binary index of the owner; valid only while busy=1, otherwise 0.
- busy  output  1  1 while in GRANT state.
- timeout  output  1  single-cycle pulse when a grant is force-released by MAX_HOLD.

Behaviour:
- Reset values (asynchronous, take effect immediately): state=IDLE, grant=4'b0000, grant_id=0, busy=0, timeout=0, ptr=0, hold_cnt=0.
- States: IDLE, GRANT. All outputs are registered; no combinational path from req or done to any output.
- IDLE, when req != 0:
  - Select the first set bit of req, searching circularly from ptr upward (ptr, ptr+1, ... mod 4).
  - On the next edge: grant=onehot(sel), grant_id=sel, busy=1, hold_cnt=0, state=GRANT.
  - Latency is one cycle from req sampled to grant visible.
- IDLE, when req == 0: remain in IDLE; all outputs 0.
- GRANT: hold_cnt increments each cycle. A release condition is evaluated each edge, in priority order:
  1. done=1: normal release.
  2. req[owner]=0: requester withdrew; normal release.
  3. hold_cnt == MAX_HOLD-1: forced release; timeout=1 for exactly one cycle, coincident with the first idle cycle.
- On release (any cause): grant=0, busy=0, grant_id=0, state=IDLE, ptr=(owner+1) mod 4, hold_cnt=0.
  - At least one idle cycle always separates two grants, including back-to-back grants to different owners.
  - The maximum tenure is therefore MAX_HOLD cycles.
- Simultaneous events:
  - done and timeout in the same cycle: done wins, so timeout stays 0.
  - Changes to other req bits during GRANT are ignored until the next arbitration.
- Fairness: with all four requesters continuously asserted, grants rotate 0,1,2,3,0,... No requester waits more than 3 tenures.
- ptr wraps from 3 to 0 (2-bit modulo arithmetic).
- hold_cnt is unsigned, CNT_W wide, and never exceeds MAX_HOLD-1.
- Reset asserted mid-grant: grant drops to 0 immediately, without waiting for a clock edge. After reset releases, arbitration restarts with ptr=0.
- Invariants:
  - grant is always zero or one-hot; never multi-hot.
  - busy == (grant != 0).
  - grant_id == index(grant) whenever busy=1.

Decomposition:
- Shared package/header holds:
  - state encoding constants IDLE=1'b0, GRANT=1'b1;
  - MAX_HOLD and CNT_W defaults;
  - a localparam NREQ=4.
- One sub-module is natural: rr_pick4, a combinational circular priority picker.
  - Inputs: req[3:0], ptr[1:0].
  - Outputs: sel[1:0], any.
  - The top level holds the state register, counter, pointer and output registers.

Test Plan:
- Reset mid-grant: assert reset at t=10 → grant, busy and timeout are 0 before the next clk edge. After release, req=4'b1000 → grant=4'b1000, grant_id=3 one cycle later.
- All-request rotation: req=4'b1111 held, done pulsed 1 cycle after each grant → grant sequence 0001,0000,0010,0000,0100,0000,1000,0000,0001.
- Priority from pointer: after owner 1 releases (ptr=2), req=4'b0011 → grant=4'b0001 (wraps past 2 and 3 to 0).
- Timeout, MAX_HOLD=8: req=4'b0100 held, done=0 → grant=4'b0100 for exactly 8 cycles, then grant=0 with timeout=1 for one cycle. Re-grant to 4'b0100 follows after the gap.
- done and timeout coincident: assert done exactly on the 8th held cycle → release occurs and timeout stays 0.
- Withdrawal: req=4'b0001 granted, req drops to 0 on cycle 3 → grant=0 on the next edge, timeout=0, ptr=1. Then req=4'b0011 → grant=4'b0010.
